// File: rtl/axis_burst_writer.sv
// Write master for one crossbar port: splits a (start address, beat count) command into
// bursts of at most MAX_BURST beats. Optional macro BURST_4K_SPLIT_EN keeps bursts inside 4 KiB pages.
module axis_burst_writer #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int STRB_WIDTH = 4,
  parameter int MAX_BURST  = 128
) (
  input  logic                  aclk,
  input  logic                  reset,
  input  logic                  s_cvalid,
  output logic                  s_cready,
  input  logic [ADDR_WIDTH-1:0] s_caddr,
  input  logic [ADDR_WIDTH-1:0] s_cbeats,
  input  logic                  s_xvalid,
  output logic                  s_xready,
  input  logic [DATA_WIDTH-1:0] s_xdata,
  input  logic [STRB_WIDTH-1:0] s_xstrb,
  output logic                  m_avalid,
  input  logic                  m_aready,
  output logic                  m_arnw,
  output logic [ADDR_WIDTH-1:0] m_aaddr,
  output logic [ADDR_WIDTH-1:0] m_abeats,
  output logic                  m_wvalid,
  input  logic                  m_wready,
  output logic                  m_wlast,
  output logic [DATA_WIDTH-1:0] m_wdata,
  output logic [STRB_WIDTH-1:0] m_wstrb,
  output logic                  busy,
  output logic                  done
);

  localparam logic [ADDR_WIDTH-1:0] StepBytes = ADDR_WIDTH'(STRB_WIDTH);
  localparam logic [ADDR_WIDTH-1:0] MaxLen    = ADDR_WIDTH'(MAX_BURST);
  localparam logic [ADDR_WIDTH-1:0] One       = ADDR_WIDTH'(1);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  state_t                state_q;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH-1:0] remain_q, remain_d;
  logic [ADDR_WIDTH-1:0] cnt_q;
  logic [ADDR_WIDTH-1:0] abeats_q;
  logic                  avalid_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  cmdFire;
  logic                  beatFire;
  logic [ADDR_WIDTH-1:0] cappedLen;
  logic [ADDR_WIDTH-1:0] burstLen_d;

  assign cmdFire  = s_cvalid && s_cready;
  assign beatFire = (state_q == DATA) && s_xvalid && m_wready;

  // addr_d/remain_d describe the transfer as it will stand after this edge, so the
  // next burst length can be registered on the same edge that enters ADDR.
  always_comb begin
    addr_d   = addr_q;
    remain_d = remain_q;
    if (cmdFire) begin
      addr_d   = s_caddr;
      remain_d = s_cbeats;
    end else if (beatFire) begin
      addr_d   = addr_q + StepBytes;
      remain_d = remain_q - One;
    end
  end

  assign cappedLen = (remain_d > MaxLen) ? MaxLen : remain_d;

`ifdef BURST_4K_SPLIT_EN
  logic [12:0]           pageRoom;
  logic [ADDR_WIDTH-1:0] pageBeats;

  assign pageRoom   = 13'd4096 - {1'b0, addr_d[11:0]};
  assign pageBeats  = ADDR_WIDTH'(pageRoom / 13'(STRB_WIDTH));
  assign burstLen_d = (cappedLen < pageBeats) ? cappedLen : pageBeats;
`else
  assign burstLen_d = cappedLen;
`endif

  always_ff @(posedge aclk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      remain_q <= '0;
      cnt_q    <= '0;
      abeats_q <= '0;
      avalid_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q   <= 1'b0;
      addr_q   <= addr_d;
      remain_q <= remain_d;
      case (state_q)
        IDLE: begin
          if (cmdFire) begin
            if (s_cbeats == '0) begin
              done_q <= 1'b1;
            end else begin
              state_q  <= ADDR;
              busy_q   <= 1'b1;
              avalid_q <= 1'b1;
              abeats_q <= burstLen_d;
            end
          end
        end
        ADDR: begin
          if (avalid_q && m_aready) begin
            avalid_q <= 1'b0;
            cnt_q    <= abeats_q;
            state_q  <= DATA;
          end
        end
        DATA: begin
          if (beatFire) begin
            cnt_q <= cnt_q - One;
            // remain_q still counts the beat being accepted on this edge
            if (cnt_q == One) begin
              if (remain_q > One) begin
                state_q  <= ADDR;
                avalid_q <= 1'b1;
                abeats_q <= burstLen_d;
              end else begin
                state_q <= IDLE;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
              end
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign s_cready = (state_q == IDLE) && !done_q;
  assign s_xready = (state_q == DATA) && m_wready;
  assign m_wvalid = (state_q == DATA) && s_xvalid;
  assign m_wlast  = (state_q == DATA) && (cnt_q == One);
  assign m_wdata  = s_xdata;
  assign m_wstrb  = s_xstrb;
  assign m_avalid = avalid_q;
  assign m_arnw   = 1'b1;
  assign m_aaddr  = addr_q;
  assign m_abeats = abeats_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_axis_burst_writer.sv
// Directed bench for axis_burst_writer: table of commands with hand-computed burst lists,
// plus sequences for reset mid-burst and a command held valid across busy.
module tb_axis_burst_writer;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = 4;
  localparam int MB = 128;

  logic          aclk = 1'b0;
  logic          reset;
  logic          s_cvalid;
  logic          s_cready;
  logic [AW-1:0] s_caddr;
  logic [AW-1:0] s_cbeats;
  logic          s_xvalid;
  logic          s_xready;
  logic [DW-1:0] s_xdata;
  logic [SW-1:0] s_xstrb;
  logic          m_avalid;
  logic          m_aready;
  logic          m_arnw;
  logic [AW-1:0] m_aaddr;
  logic [AW-1:0] m_abeats;
  logic          m_wvalid;
  logic          m_wready;
  logic          m_wlast;
  logic [DW-1:0] m_wdata;
  logic [SW-1:0] m_wstrb;
  logic          busy;
  logic          done;

  axis_burst_writer #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .STRB_WIDTH(SW), .MAX_BURST(MB)
  ) dut (
    .aclk(aclk), .reset(reset),
    .s_cvalid(s_cvalid), .s_cready(s_cready), .s_caddr(s_caddr), .s_cbeats(s_cbeats),
    .s_xvalid(s_xvalid), .s_xready(s_xready), .s_xdata(s_xdata), .s_xstrb(s_xstrb),
    .m_avalid(m_avalid), .m_aready(m_aready), .m_arnw(m_arnw),
    .m_aaddr(m_aaddr), .m_abeats(m_abeats),
    .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wlast(m_wlast),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .busy(busy), .done(done)
  );

  always #5 aclk = ~aclk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] beats;
    int          xStall;
    int          wStall;
    int          aDelay;
    int          expBursts;
    logic [31:0] firstAddr;
    logic [31:0] firstLen;
    logic [31:0] lastAddr;
    logic [31:0] lastLen;
    int          expWlast;
  } vec_t;

  int checks = 0;
  int failures = 0;

  int xStall = 0;
  int wStall = 0;
  int aDelay = 0;
  int aWait = 0;
  int xSeq = 0;
  int wSeq = 0;
  int curLeft = 0;
  int wlastCount = 0;
  int doneCount = 0;
  bit prevAWait = 1'b0;
  logic [31:0] prevAddr;
  logic [31:0] prevBeats;
  logic [31:0] burstAddrQ[$];
  logic [31:0] burstLenQ[$];

  function automatic logic [31:0] dataOf(input int n);
    return 32'hD000_0000 + 32'(n);
  endfunction

  function automatic logic [3:0] strbOf(input int n);
    return 4'(n * 3 + 1);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic clearMonitor();
    xSeq = 0;
    wSeq = 0;
    curLeft = 0;
    wlastCount = 0;
    doneCount = 0;
    burstAddrQ.delete();
    burstLenQ.delete();
  endtask

  // Environment: monitor/scoreboard at negedge, drive slave-side inputs just after posedge.
  initial begin
    bit aFire, wFire, xFire;
    m_aready = 1'b0;
    s_xvalid = 1'b0;
    m_wready = 1'b0;
    s_xdata  = '0;
    s_xstrb  = '0;
    forever begin
      @(negedge aclk);
      aFire = m_avalid && m_aready;
      wFire = m_wvalid && m_wready;
      xFire = s_xvalid && s_xready;
      if (!reset) begin
        if (prevAWait) begin
          checkOutput("aValidHold", {31'b0, m_avalid}, 32'd1);
          checkOutput("aAddrHold", m_aaddr, prevAddr);
          checkOutput("aBeatsHold", m_abeats, prevBeats);
        end
        prevAWait = m_avalid && !m_aready;
        prevAddr  = m_aaddr;
        prevBeats = m_abeats;
        if (aFire) begin
          checkOutput("oneOutstanding", 32'(curLeft), 32'd0);
          burstAddrQ.push_back(m_aaddr);
          burstLenQ.push_back(m_abeats);
          curLeft = int'(m_abeats);
        end
        if (m_wvalid) checkOutput("wvalidInBurst", {31'b0, curLeft != 0}, 32'd1);
        if (wFire) begin
          checkOutput("wdata", m_wdata, dataOf(wSeq));
          checkOutput("wstrb", {28'b0, m_wstrb}, {28'b0, strbOf(wSeq)});
          checkOutput("wlast", {31'b0, m_wlast}, {31'b0, curLeft == 1});
          if (m_wlast) wlastCount++;
          curLeft--;
          wSeq++;
        end
        if (done) doneCount++;
      end else begin
        prevAWait = 1'b0;
      end
      @(posedge aclk);
      #1;
      if (reset) begin
        m_aready = 1'b0;
        aWait = 0;
      end else if (m_aready) begin
        m_aready = 1'b0;
      end else if (m_avalid) begin
        if (aWait >= aDelay) begin
          m_aready = 1'b1;
          aWait = 0;
        end else begin
          aWait++;
        end
      end
      if (xFire) xSeq++;
      s_xvalid = ($urandom_range(99) >= xStall);
      m_wready = ($urandom_range(99) >= wStall);
      s_xdata  = dataOf(xSeq);
      s_xstrb  = strbOf(xSeq);
    end
  end

  task automatic waitReady(input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge aclk);
      if (s_cready) begin
        seen = 1'b1;
        break;
      end
    end
    checkOutput({tag, ".creadyTimeout"}, {31'b0, seen}, 32'd1);
  endtask

  task automatic waitDone(input int maxCycles, input string tag, output int lat);
    bit seen = 1'b0;
    lat = 0;
    for (int i = 0; i < maxCycles; i++) begin
      @(negedge aclk);
      lat++;
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    checkOutput({tag, ".doneTimeout"}, {31'b0, seen}, 32'd1);
  endtask

  task automatic applyStimulus(input vec_t v, input string tag);
    int lat;
    xStall = v.xStall;
    wStall = v.wStall;
    aDelay = v.aDelay;
    clearMonitor();
    s_caddr  = v.addr;
    s_cbeats = v.beats;
    s_cvalid = 1'b1;
    waitReady(tag);
    @(posedge aclk);
    #1;
    s_cvalid = 1'b0;
    waitDone(int'(v.beats) * 20 + 200, tag, lat);
    repeat (3) @(posedge aclk);
    #1;
    checkOutput({tag, ".bursts"}, 32'(burstAddrQ.size()), 32'(v.expBursts));
    if (v.expBursts > 0 && burstAddrQ.size() > 0) begin
      checkOutput({tag, ".firstAddr"}, burstAddrQ[0], v.firstAddr);
      checkOutput({tag, ".firstLen"}, burstLenQ[0], v.firstLen);
      checkOutput({tag, ".lastAddr"}, burstAddrQ[$], v.lastAddr);
      checkOutput({tag, ".lastLen"}, burstLenQ[$], v.lastLen);
    end
    for (int i = 1; i < burstAddrQ.size(); i++)
      checkOutput({tag, ".contig"}, burstAddrQ[i], burstAddrQ[i-1] + burstLenQ[i-1] * 32'(SW));
    checkOutput({tag, ".beats"}, 32'(wSeq), v.beats);
    checkOutput({tag, ".wlastCount"}, 32'(wlastCount), 32'(v.expWlast));
    checkOutput({tag, ".doneCount"}, 32'(doneCount), 32'd1);
    if (v.beats == 0) checkOutput({tag, ".doneLatency"}, 32'(lat), 32'd1);
    checkOutput({tag, ".busyAfter"}, {31'b0, busy}, 32'd0);
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, ".avalid"}, {31'b0, m_avalid}, 32'd0);
    checkOutput({tag, ".wvalid"}, {31'b0, m_wvalid}, 32'd0);
    checkOutput({tag, ".wlast"}, {31'b0, m_wlast}, 32'd0);
    checkOutput({tag, ".xready"}, {31'b0, s_xready}, 32'd0);
    checkOutput({tag, ".busy"}, {31'b0, busy}, 32'd0);
    checkOutput({tag, ".done"}, {31'b0, done}, 32'd0);
    checkOutput({tag, ".cready"}, {31'b0, s_cready}, 32'd1);
    checkOutput({tag, ".aaddr"}, m_aaddr, 32'd0);
    checkOutput({tag, ".abeats"}, m_abeats, 32'd0);
    checkOutput({tag, ".arnw"}, {31'b0, m_arnw}, 32'd1);
  endtask

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vec_t vecs[8];
    vec_t postReset;
    int lat;
    bit reached;
    bit sawDone;

    vecs[0] = '{32'h0000_1000, 32'd300, 0, 0, 0, 3, 32'h0000_1000, 32'd128, 32'h0000_1400, 32'd44, 3};
    vecs[1] = '{32'h0000_2000, 32'd0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 32'h0, 0};
    vecs[2] = '{32'h0000_3000, 32'd5, 40, 40, 7, 1, 32'h0000_3000, 32'd5, 32'h0000_3000, 32'd5, 1};
`ifdef BURST_4K_SPLIT_EN
    vecs[3] = '{32'h0000_0FF0, 32'd8, 0, 0, 1, 2, 32'h0000_0FF0, 32'd4, 32'h0000_1000, 32'd4, 2};
    vecs[7] = '{32'hFFFF_FFF8, 32'd4, 0, 0, 0, 2, 32'hFFFF_FFF8, 32'd2, 32'h0000_0000, 32'd2, 2};
`else
    vecs[3] = '{32'h0000_0FF0, 32'd8, 0, 0, 1, 1, 32'h0000_0FF0, 32'd8, 32'h0000_0FF0, 32'd8, 1};
    vecs[7] = '{32'hFFFF_FFF8, 32'd4, 0, 0, 0, 1, 32'hFFFF_FFF8, 32'd4, 32'hFFFF_FFF8, 32'd4, 1};
`endif
    vecs[4] = '{32'h0000_4000, 32'd128, 20, 20, 3, 1, 32'h0000_4000, 32'd128, 32'h0000_4000, 32'd128, 1};
    vecs[5] = '{32'h0000_5000, 32'd129, 0, 30, 2, 2, 32'h0000_5000, 32'd128, 32'h0000_5200, 32'd1, 2};
    vecs[6] = '{32'h0000_6000, 32'd1, 30, 0, 0, 1, 32'h0000_6000, 32'd1, 32'h0000_6000, 32'd1, 1};
    postReset = '{32'h0000_7000, 32'd10, 0, 0, 0, 1, 32'h0000_7000, 32'd10, 32'h0000_7000, 32'd10, 1};

    reset    = 1'b1;
    s_cvalid = 1'b0;
    s_caddr  = '0;
    s_cbeats = '0;
    repeat (3) @(posedge aclk);
    #1;
    checkResetValues("reset");
    reset = 1'b0;
    repeat (2) @(posedge aclk);
    #1;

    for (int i = 0; i < 8; i++) applyStimulus(vecs[i], $sformatf("vec%0d", i));

    // Reset in the middle of the second burst of a 300-beat command.
    xStall = 0;
    wStall = 0;
    aDelay = 0;
    clearMonitor();
    s_caddr  = 32'h0000_1000;
    s_cbeats = 32'd300;
    s_cvalid = 1'b1;
    waitReady("midReset");
    @(posedge aclk);
    #1;
    s_cvalid = 1'b0;
    reached = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge aclk);
      if (wSeq >= 138) begin
        reached = 1'b1;
        break;
      end
    end
    checkOutput("midReset.reachBurst2", {31'b0, reached}, 32'd1);
    @(posedge aclk);
    #3;
    checkOutput("midReset.busyBefore", {31'b0, busy}, 32'd1);
    reset = 1'b1;
    #1;
    checkResetValues("midReset");
    repeat (2) @(posedge aclk);
    #1;
    reset = 1'b0;
    @(posedge aclk);
    #1;
    applyStimulus(postReset, "postReset");

    // Command valid held high across busy: second command only after done.
    xStall = 0;
    wStall = 0;
    aDelay = 2;
    clearMonitor();
    s_caddr  = 32'h0000_8000;
    s_cbeats = 32'd3;
    s_cvalid = 1'b1;
    waitReady("heldValid");
    @(posedge aclk);
    #1;
    s_caddr  = 32'h0000_9000;
    s_cbeats = 32'd2;
    sawDone  = 1'b0;
    reached  = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge aclk);
      if (done) begin
        sawDone = 1'b1;
        checkOutput("heldValid.creadyAtDone", {31'b0, s_cready}, 32'd0);
      end else if (sawDone) begin
        checkOutput("heldValid.creadyAfterDone", {31'b0, s_cready}, 32'd1);
        reached = 1'b1;
        break;
      end else begin
        checkOutput("heldValid.creadyBusy", {31'b0, s_cready}, 32'd0);
      end
    end
    checkOutput("heldValid.secondAccepted", {31'b0, reached}, 32'd1);
    @(posedge aclk);
    #1;
    s_cvalid = 1'b0;
    waitDone(300, "heldValid2", lat);
    repeat (3) @(posedge aclk);
    #1;
    checkOutput("heldValid.bursts", 32'(burstAddrQ.size()), 32'd2);
    if (burstAddrQ.size() == 2) begin
      checkOutput("heldValid.addr0", burstAddrQ[0], 32'h0000_8000);
      checkOutput("heldValid.len0", burstLenQ[0], 32'd3);
      checkOutput("heldValid.addr1", burstAddrQ[1], 32'h0000_9000);
      checkOutput("heldValid.len1", burstLenQ[1], 32'd2);
    end
    checkOutput("heldValid.beats", 32'(wSeq), 32'd5);
    checkOutput("heldValid.wlastCount", 32'(wlastCount), 32'd2);
    checkOutput("heldValid.doneCount", 32'(doneCount), 32'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
